jtag_host: RTL and testbench



---
 rtl/jtag_host_pkg.sv | 48 ++++
 rtl/jtag_tck_divider.sv | 44 ++++
 rtl/jtag_host.sv | 155 +++++++++++++++
 tb/tb_jtag_host.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared encodings and TMS sequences for the JTAG host
package jtag_host_pkg;

   localparam int MAX_LENGTH = 32;

   typedef enum logic [1:0] {
      CMD_TLR_RESET   = 2'd0,
      CMD_IR_SCAN     = 2'd1,
      CMD_DR_SCAN     = 2'd2,
      CMD_IDLE_CLOCKS = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      ST_INIT_RESET = 3'd0,
      ST_IDLE       = 3'd1,
      ST_PREAMBLE   = 3'd2,
      ST_SHIFT      = 3'd3,
      ST_POSTAMBLE  = 3'd4,
      ST_RESPOND    = 3'd5
   } state_e;

   // Bit i holds the TMS value driven during TCK i of the sequence.
   localparam logic [5:0] TMS_TLR    = 6'b011111;
   localparam logic [5:0] TMS_PRE_IR = 6'b000011;
   localparam logic [5:0] TMS_PRE_DR = 6'b000001;
   localparam logic [1:0] TMS_POST   = 2'b01;

   function automatic logic [5:0] pre_tms(cmd_type_e t);
      case (t)
         CMD_IR_SCAN: pre_tms = TMS_PRE_IR;
         CMD_DR_SCAN: pre_tms = TMS_PRE_DR;
         default:     pre_tms = TMS_TLR;
      endcase
   endfunction

   function automatic logic [5:0] pre_last(cmd_type_e t);
      case (t)
         CMD_IR_SCAN: pre_last = 6'd3;
         CMD_DR_SCAN: pre_last = 6'd2;
         default:     pre_last = 6'd5;
      endcase
   endfunction

   function automatic logic length_ok(logic [5:0] len);
      length_ok = (len != 6'd0) && (len <= 6'(MAX_LENGTH));
   endfunction

endpackage

// File: rtl/jtag_tck_divider.sv
// rtl/jtag_tck_divider.sv - TCK generator with one-cycle rise/fall strobes
// Each phase lasts DIV clk cycles; disabling parks TCK low with the counter cleared.
module jtag_tck_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          last;

   always_comb begin
      last  = (cnt_q == CW'(DIV - 1));
      cnt_d = '0;
      tck_d = 1'b0;
      if (en) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
         tck_d = tck_q ^ last;
      end
      rise_stb = en && last && !tck_q;
      fall_stb = en && last && tck_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   assign tck = tck_q;

endmodule

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG TAP host running reset, IR/DR scan and idle-clock commands
// The FSM advances only on divider strobes; TMS/TDI are registered from the next state.
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int CLOCK_DIVIDE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [5:0]  cmd_length,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_error,
   output logic        busy,
   output logic        jtag_tck,
   output logic        jtag_tms,
   output logic        jtag_tdi,
   input  logic        jtag_tdo
);

   state_e      state_q, state_d;
   cmd_type_e   type_q, type_d;
   logic [5:0]  bit_q, bit_d;
   logic [5:0]  len_q, len_d;
   logic [31:0] data_q, data_d;
   logic [31:0] rsp_q, rsp_d;
   logic        err_q, err_d;
   logic        tms_q, tms_d;
   logic        tdi_q, tdi_d;
   logic        arm_q;
   logic [5:0]  pre_pat;
   logic        div_en, rise_stb, fall_stb;

   // arm_q holds off the first low phase until the edge after reset release.
   assign div_en = arm_q && !err_q &&
                   (state_q inside {ST_INIT_RESET, ST_PREAMBLE, ST_SHIFT, ST_POSTAMBLE});

   jtag_tck_divider #(.DIV(CLOCK_DIVIDE)) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (div_en),
      .tck      (jtag_tck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT_RESET;
         type_q  <= CMD_TLR_RESET;
         bit_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         bit_q   <= bit_d;
         len_q   <= len_d;
         data_q  <= data_d;
         rsp_q   <= rsp_d;
         err_q   <= err_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         arm_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      bit_d   = bit_q;
      len_d   = len_q;
      data_d  = data_q;
      rsp_d   = rsp_q;
      err_d   = err_q;
      case (state_q)
         ST_INIT_RESET: if (fall_stb) begin
            if (bit_q == 6'd5) begin
               state_d = ST_IDLE;
               bit_d   = '0;
            end else bit_d = bit_q + 6'd1;
         end
         ST_IDLE: if (cmd_valid) begin
            type_d  = cmd_type_e'(cmd_type);
            len_d   = cmd_length;
            data_d  = cmd_data;
            rsp_d   = '0;
            bit_d   = '0;
            err_d   = (type_d != CMD_TLR_RESET) && !length_ok(cmd_length);
            state_d = (type_d == CMD_IDLE_CLOCKS && !err_d) ? ST_SHIFT : ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            if (err_q) state_d = ST_RESPOND;
            else if (fall_stb) begin
               if (bit_q == pre_last(type_q)) begin
                  bit_d   = '0;
                  state_d = (type_q == CMD_TLR_RESET) ? ST_RESPOND : ST_SHIFT;
               end else bit_d = bit_q + 6'd1;
            end
         end
         ST_SHIFT: begin
            if (rise_stb && type_q != CMD_IDLE_CLOCKS) rsp_d[bit_q[4:0]] = jtag_tdo;
            if (fall_stb) begin
               if (bit_q == len_q - 6'd1) begin
                  bit_d   = '0;
                  state_d = (type_q == CMD_IDLE_CLOCKS) ? ST_RESPOND : ST_POSTAMBLE;
               end else bit_d = bit_q + 6'd1;
            end
         end
         ST_POSTAMBLE: if (fall_stb) begin
            if (bit_q == 6'd1) begin
               bit_d   = '0;
               state_d = ST_RESPOND;
            end else bit_d = bit_q + 6'd1;
         end
         ST_RESPOND: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_INIT_RESET;
      endcase
   end

   always_comb begin
      tms_d   = 1'b0;
      tdi_d   = 1'b0;
      pre_pat = pre_tms(type_d);
      case (state_d)
         ST_INIT_RESET: tms_d = TMS_TLR[bit_d[2:0]];
         ST_PREAMBLE:   tms_d = !err_d && pre_pat[bit_d[2:0]];
         ST_SHIFT: if (type_d != CMD_IDLE_CLOCKS) begin
            tms_d = (bit_d == len_d - 6'd1);
            tdi_d = data_d[bit_d[4:0]];
         end
         ST_POSTAMBLE:  tms_d = TMS_POST[bit_d[0]];
         default: ;
      endcase
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESPOND);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_data  = rsp_q;
   assign rsp_error = rsp_valid && err_q;
   assign jtag_tms  = tms_q;
   assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - self-checking bench for jtag_host against a 1149.1 TAP model
module tb_jtag_host;

   localparam int          D          = 4;
   localparam logic [31:0] IDCODE_VAL = 32'h1ABCD247;
   localparam logic [4:0]  IR_IDCODE  = 5'h04;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_error, busy;
   logic [1:0]  cmd_type;
   logic [5:0]  cmd_length;
   logic [31:0] cmd_data, rsp_data;
   logic        jtag_tck, jtag_tms, jtag_tdi;
   logic        tdo_r = 1'b0;

   int          errors = 0, checks = 0;
   int          tck_cnt = 0, hi_changes = 0;
   logic [31:0] tms_hist = '0;
   logic        tms_at_rise = 1'b0, tdi_at_rise = 1'b0;

   jtag_host #(.CLOCK_DIVIDE(D)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_length(cmd_length), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .busy(busy),
      .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(tdo_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Target TAP: IR 5 bits, IDCODE selected on Test-Logic-Reset, everything else BYPASS.
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
      T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
   } tap_e;

   tap_e        tap = T_SH_DR;
   logic [31:0] dr_sr = '0;
   logic [4:0]  ir_sr = '0, ir_reg = IR_IDCODE;

   function automatic tap_e tap_next(tap_e s, logic tms);
      case (s)
         T_TLR:    return tms ? T_TLR    : T_RTI;
         T_RTI:    return tms ? T_SEL_DR : T_RTI;
         T_SEL_DR: return tms ? T_SEL_IR : T_CAP_DR;
         T_CAP_DR: return tms ? T_EX1_DR : T_SH_DR;
         T_SH_DR:  return tms ? T_EX1_DR : T_SH_DR;
         T_EX1_DR: return tms ? T_UPD_DR : T_PA_DR;
         T_PA_DR:  return tms ? T_EX2_DR : T_PA_DR;
         T_EX2_DR: return tms ? T_UPD_DR : T_SH_DR;
         T_UPD_DR: return tms ? T_SEL_DR : T_RTI;
         T_SEL_IR: return tms ? T_TLR    : T_CAP_IR;
         T_CAP_IR: return tms ? T_EX1_IR : T_SH_IR;
         T_SH_IR:  return tms ? T_EX1_IR : T_SH_IR;
         T_EX1_IR: return tms ? T_UPD_IR : T_PA_IR;
         T_PA_IR:  return tms ? T_EX2_IR : T_PA_IR;
         T_EX2_IR: return tms ? T_UPD_IR : T_SH_IR;
         default:  return tms ? T_SEL_DR : T_RTI;
      endcase
   endfunction

   always @(posedge jtag_tck) begin
      tck_cnt++;
      tms_hist    = {tms_hist[30:0], jtag_tms};
      tms_at_rise = jtag_tms;
      tdi_at_rise = jtag_tdi;
      case (tap)
         T_TLR:    ir_reg = IR_IDCODE;
         T_CAP_DR: dr_sr = (ir_reg == IR_IDCODE) ? IDCODE_VAL : 32'h0;
         T_SH_DR:  if (ir_reg == IR_IDCODE) dr_sr = {jtag_tdi, dr_sr[31:1]};
                   else dr_sr[0] = jtag_tdi;
         T_CAP_IR: ir_sr = 5'b00001;
         T_SH_IR:  ir_sr = {jtag_tdi, ir_sr[4:1]};
         T_UPD_IR: ir_reg = ir_sr;
         default: ;
      endcase
      tap = tap_next(tap, jtag_tms);
   end

   always @(negedge jtag_tck)
      tdo_r = (tap == T_SH_DR) ? dr_sr[0] : (tap == T_SH_IR) ? ir_sr[0] : 1'b0;

   always @(negedge clk)
      if (!rst && jtag_tck === 1'b1 && (jtag_tms !== tms_at_rise || jtag_tdi !== tdi_at_rise))
         hi_changes++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask(int len);
      return (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
   endfunction

   function automatic int total_tck(logic [1:0] t, int len);
      case (t)
         2'd0:    return 6;
         2'd1:    return len + 6;
         2'd2:    return len + 5;
         default: return len;
      endcase
   endfunction

   task automatic wait_init(input string tag);
      int cyc, t0;
      tms_hist = '0;
      t0  = tck_cnt;
      cyc = 0;
      do begin
         @(posedge clk); cyc++; @(negedge clk);
      end while (!cmd_ready && cyc < 2000);
      chk({tag, "/ready_edge"}, cyc, 12 * D + 1);
      chk({tag, "/tck_count"}, tck_cnt - t0, 6);
      chk({tag, "/tms_seq"}, tms_hist[5:0], 6'b111110);
      chk({tag, "/tap_rti"}, tap, T_RTI);
      chk({tag, "/busy"}, busy, 1'b0);
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] t, input int len,
                          input logic [31:0] d, input logic [31:0] exp_data,
                          input logic exp_err, input int stall);
      int n, cyc, t0;
      logic [31:0] held;
      logic stable;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_type   = t;
      cmd_length = len[5:0];
      cmd_data   = d;
      rsp_ready  = (stall == 0);
      n = 0;
      while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "/ready"}, cmd_ready, 1'b1);
      t0 = tck_cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); cyc++; @(negedge clk);
      end while (!rsp_valid && cyc < 2000);
      chk({tag, "/latency"}, cyc, exp_err ? 1 : total_tck(t, len) * 2 * D);
      chk({tag, "/tck_count"}, tck_cnt - t0, exp_err ? 0 : total_tck(t, len));
      chk({tag, "/data"}, rsp_data, exp_data);
      chk({tag, "/error"}, rsp_error, exp_err);
      chk({tag, "/tap_rti"}, tap, T_RTI);
      if (stall > 0) begin
         held   = rsp_data;
         stable = 1'b1;
         t0     = tck_cnt;
         repeat (stall) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) stable = 1'b0;
         end
         chk({tag, "/stall_hold"}, stable, 1'b1);
         chk({tag, "/stall_tck"}, tck_cnt - t0, 0);
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "/ready_after"}, {cmd_ready, rsp_valid}, 2'b10);
   endtask

   initial begin
      int n, t0, len;
      logic [31:0] d;
      rst = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_length = '0; cmd_data = '0;
      rsp_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("reset/tck", jtag_tck, 1'b0);
      chk("reset/tms", jtag_tms, 1'b1);
      chk("reset/tdi", jtag_tdi, 1'b0);
      chk("reset/handshake", {cmd_ready, rsp_valid, rsp_error}, 3'b000);
      chk("reset/rsp_data", rsp_data, 32'h0);
      chk("reset/busy", busy, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_init("power_on");

      run_cmd("ir_idcode", 2'd1, 5, 32'h04, 32'h01, 1'b0, 0);
      run_cmd("dr_idcode", 2'd2, 32, 32'h0, IDCODE_VAL, 1'b0, 0);
      run_cmd("ir_bypass", 2'd1, 5, 32'h1F, 32'h01, 1'b0, 0);
      run_cmd("dr_bypass_a5", 2'd2, 8, 32'hA5, 32'h4A, 1'b0, 0);
      d = $urandom;
      run_cmd("dr_bypass_len1", 2'd2, 1, d, 32'h0, 1'b0, 0);
      d = $urandom;
      run_cmd("dr_bypass_len32", 2'd2, 32, d, d << 1, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         len = int'($urandom_range(32, 1));
         d   = $urandom;
         run_cmd("dr_bypass_rand", 2'd2, len, d, (d << 1) & mask(len), 1'b0, 0);
      end

      run_cmd("err_len0", 2'd2, 0, $urandom, 32'h0, 1'b1, 0);
      run_cmd("err_len33", 2'd1, 33, $urandom, 32'h0, 1'b1, 0);
      run_cmd("err_idle_len0", 2'd3, 0, 32'h0, 32'h0, 1'b1, 0);
      for (int i = 0; i < 2; i++)
         run_cmd("idle_clocks", 2'd3, int'($urandom_range(32, 1)), $urandom, 32'h0, 1'b0, 0);

      run_cmd("tlr_reset", 2'd0, 0, 32'h0, 32'h0, 1'b0, 0);
      for (int i = 0; i < 2; i++) begin
         len = int'($urandom_range(32, 1));
         run_cmd("dr_idcode_rand", 2'd2, len, $urandom, IDCODE_VAL & mask(len), 1'b0, 0);
      end
      run_cmd("dr_stall", 2'd2, 32, 32'h0, IDCODE_VAL, 1'b0, 20);

      @(negedge clk);
      cmd_valid = 1'b1; cmd_type = 2'd2; cmd_length = 6'd32; cmd_data = $urandom;
      rsp_ready = 1'b1;
      n = 0;
      while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
      t0 = tck_cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (tck_cnt - t0 < 14 && n < 2000) begin @(negedge clk); n++; end
      chk("rst_mid/reached_bit10", tck_cnt - t0, 14);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid/pins", {jtag_tck, jtag_tms}, 2'b01);
      chk("rst_mid/handshake", {cmd_ready, rsp_valid, busy}, 3'b001);
      chk("rst_mid/rsp_data", rsp_data, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_init("rst_mid_init");
      run_cmd("dr_after_rst", 2'd2, 32, 32'h0, IDCODE_VAL, 1'b0, 0);

      chk("tms_tdi_stable_high", hi_changes, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
